// File: rtl/step_scheduler_if.sv
// rtl/step_scheduler_if.sv - move-command handshake bundle for the step scheduler
interface step_scheduler_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dir;
  logic [15:0] cmd_steps;
  logic [15:0] cmd_period;

  modport master (output cmd_valid, cmd_dir, cmd_steps, cmd_period, input cmd_ready);
  modport slave  (input cmd_valid, cmd_dir, cmd_steps, cmd_period, output cmd_ready);
endinterface

// File: rtl/step_scheduler.sv
// rtl/step_scheduler.sv - step/dir pulse generator with one active and one pending move
// A move of N steps emits N pulses of STEP_HIGH_CYCLES, spaced by the clamped period.
module step_scheduler #(
  parameter int STEP_HIGH_CYCLES = 8,
  parameter int DIR_SETUP_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  step_scheduler_if.slave    cmd,
  input  logic               abort,
  input  logic               hold_enable,
  output logic               step,
  output logic               dir,
  output logic               enable,
  output logic               busy,
  output logic               move_done,
  output logic               abort_done,
  output logic [15:0]        steps_remaining
);

  localparam logic [15:0] SH16       = 16'(STEP_HIGH_CYCLES);
  localparam logic [15:0] MIN_PERIOD = 16'(2 * STEP_HIGH_CYCLES);

  typedef enum logic [1:0] {IDLE, DIR_SETUP, STEP_HIGH, STEP_LOW} state_t;
  typedef struct packed {
    state_t      state;
    logic [15:0] cnt;
    logic [15:0] steps;
    logic        dir;
  } load_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, steps_q, steps_d, period_q, period_d;
  logic        dir_q, dir_d, step_q, step_d, enable_q, enable_d;
  logic        abort_done_q, abort_done_d, abort_lat_q, abort_lat_d;
  logic        pend_valid_q, pend_valid_d, pend_dir_q, pend_dir_d;
  logic [15:0] pend_steps_q, pend_steps_d, pend_period_q, pend_period_d;
  logic        accept, ready_c, busy_c, go_abort, abort_seen;
  logic [15:0] in_period;
  load_t       ld_cmd, ld_pend;

  // cnt holds the cycles left in the current state, including the present one
  function automatic load_t do_load(input logic ldir, input logic [15:0] lsteps,
                                    input logic cur_dir);
    load_t r;
    if (lsteps == 16'd0) begin
      r.state = STEP_LOW; r.cnt = 16'd1; r.steps = 16'd0; r.dir = cur_dir;
    end else if (ldir != cur_dir && DIR_SETUP_CYCLES != 0) begin
      r.state = DIR_SETUP; r.cnt = 16'(DIR_SETUP_CYCLES); r.steps = lsteps; r.dir = ldir;
    end else begin
      r.state = STEP_HIGH; r.cnt = SH16; r.steps = lsteps - 16'd1; r.dir = ldir;
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      steps_q       <= '0;
      period_q      <= '0;
      dir_q         <= 1'b0;
      step_q        <= 1'b0;
      enable_q      <= 1'b0;
      abort_done_q  <= 1'b0;
      abort_lat_q   <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_dir_q    <= 1'b0;
      pend_steps_q  <= '0;
      pend_period_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      steps_q       <= steps_d;
      period_q      <= period_d;
      dir_q         <= dir_d;
      step_q        <= step_d;
      enable_q      <= enable_d;
      abort_done_q  <= abort_done_d;
      abort_lat_q   <= abort_lat_d;
      pend_valid_q  <= pend_valid_d;
      pend_dir_q    <= pend_dir_d;
      pend_steps_q  <= pend_steps_d;
      pend_period_q <= pend_period_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    steps_d       = steps_q;
    period_d      = period_q;
    dir_d         = dir_q;
    abort_lat_d   = abort_lat_q;
    abort_done_d  = 1'b0;
    pend_valid_d  = pend_valid_q;
    pend_dir_d    = pend_dir_q;
    pend_steps_d  = pend_steps_q;
    pend_period_d = pend_period_q;
    go_abort      = 1'b0;
    abort_seen    = abort_lat_q | abort;
    in_period     = (cmd.cmd_period < MIN_PERIOD) ? MIN_PERIOD : cmd.cmd_period;
    ld_cmd        = do_load(cmd.cmd_dir, cmd.cmd_steps, dir_q);
    ld_pend       = do_load(pend_dir_q, pend_steps_q, dir_q);

    if (accept && state_q != IDLE) begin
      pend_valid_d  = 1'b1;
      pend_dir_d    = cmd.cmd_dir;
      pend_steps_d  = cmd.cmd_steps;
      pend_period_d = in_period;
    end

    unique case (state_q)
      IDLE: begin
        abort_lat_d = 1'b0;
        if (accept) begin
          state_d = ld_cmd.state; cnt_d = ld_cmd.cnt; steps_d = ld_cmd.steps;
          dir_d = ld_cmd.dir; period_d = in_period;
        end
      end
      DIR_SETUP: begin
        if (abort) go_abort = 1'b1;
        else if (cnt_q == 16'd1) begin
          state_d = STEP_HIGH; cnt_d = SH16; steps_d = steps_q - 16'd1;
        end else cnt_d = cnt_q - 16'd1;
      end
      STEP_HIGH: begin
        // a pulse that has started always runs to full width
        abort_lat_d = abort_seen;
        if (cnt_q == 16'd1) begin
          if (abort_seen) go_abort = 1'b1;
          else begin
            state_d = STEP_LOW; cnt_d = period_q - SH16;
          end
        end else cnt_d = cnt_q - 16'd1;
      end
      STEP_LOW: begin
        if (abort) go_abort = 1'b1;
        else if (cnt_q == 16'd1) begin
          if (steps_q != 16'd0) begin
            state_d = STEP_HIGH; cnt_d = SH16; steps_d = steps_q - 16'd1;
          end else if (pend_valid_q) begin
            state_d = ld_pend.state; cnt_d = ld_pend.cnt; steps_d = ld_pend.steps;
            dir_d = ld_pend.dir; period_d = pend_period_q; pend_valid_d = 1'b0;
          end else if (accept) begin
            // a command arriving on the completion edge goes straight to active
            state_d = ld_cmd.state; cnt_d = ld_cmd.cnt; steps_d = ld_cmd.steps;
            dir_d = ld_cmd.dir; period_d = in_period; pend_valid_d = 1'b0;
          end else state_d = IDLE;
        end else cnt_d = cnt_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase

    if (abort && state_q != IDLE) pend_valid_d = 1'b0;
    if (go_abort) begin
      state_d = IDLE; steps_d = '0; abort_done_d = 1'b1;
      abort_lat_d = 1'b0; pend_valid_d = 1'b0;
    end
    step_d   = (state_d == STEP_HIGH);
    enable_d = busy_c | hold_enable;
  end

  always_comb begin
    busy_c    = (state_q != IDLE) || pend_valid_q;
    ready_c   = !reset && !pend_valid_q && !abort_lat_q && !abort;
    accept    = cmd.cmd_valid && ready_c;
    move_done = (state_q == STEP_LOW) && (cnt_q == 16'd1) && (steps_q == 16'd0) && !abort;
  end

  assign cmd.cmd_ready     = ready_c;
  assign busy              = busy_c;
  assign step              = step_q;
  assign dir               = dir_q;
  assign enable            = enable_q;
  assign abort_done        = abort_done_q;
  assign steps_remaining   = steps_q;

endmodule

// File: tb/tb_step_scheduler.sv
// tb/tb_step_scheduler.sv - directed self-checking bench for step_scheduler
module tb_step_scheduler;
  logic        clk = 1'b0;
  logic        reset, abort, hold_enable;
  logic        step, dir, enable, busy, move_done, abort_done;
  logic [15:0] steps_remaining;

  step_scheduler_if sif();

  step_scheduler #(.STEP_HIGH_CYCLES(8), .DIR_SETUP_CYCLES(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd             (sif),
    .abort           (abort),
    .hold_enable     (hold_enable),
    .step            (step),
    .dir             (dir),
    .enable          (enable),
    .busy            (busy),
    .move_done       (move_done),
    .abort_done      (abort_done),
    .steps_remaining (steps_remaining)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] step_v, md_v, ad_v, busy_v, en_v, dir_v, rdy_v;
  logic [15:0]  rem_a [0:127];
  logic         acc;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] win(input int lo, input int hi);
    logic [127:0] v;
    v = '0;
    for (int i = lo; i <= hi; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Called at a negedge; the command is accepted on the next posedge (edge N),
  // and cycle c is sampled at the c-th negedge after it.
  task automatic run_move(input logic d, input logic [15:0] s, input logic [15:0] p, input int n,
                          input int q_at, input logic qd, input logic [15:0] qs,
                          input logic [15:0] qp, input int ab_at);
    sif.cmd_dir = d; sif.cmd_steps = s; sif.cmd_period = p; sif.cmd_valid = 1'b1;
    step_v = '0; md_v = '0; ad_v = '0; busy_v = '0; en_v = '0; dir_v = '0; rdy_v = '0;
    @(posedge clk);
    #1 sif.cmd_valid = 1'b0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      step_v[c] = step; md_v[c] = move_done; ad_v[c] = abort_done; busy_v[c] = busy;
      en_v[c] = enable; dir_v[c] = dir; rdy_v[c] = sif.cmd_ready; rem_a[c] = steps_remaining;
      if (q_at != 0 && c == q_at) begin
        sif.cmd_dir = qd; sif.cmd_steps = qs; sif.cmd_period = qp; sif.cmd_valid = 1'b1;
      end else sif.cmd_valid = 1'b0;
      abort = (c == ab_at);
    end
    abort = 1'b0; sif.cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; abort = 1'b0; hold_enable = 1'b0;
    sif.cmd_valid = 1'b0; sif.cmd_dir = 1'b0; sif.cmd_steps = '0; sif.cmd_period = '0;
    repeat (3) @(negedge clk);
    check("rst_step", step, 0);
    check("rst_dir", dir, 0);
    check("rst_enable", enable, 0);
    check("rst_busy", busy, 0);
    check("rst_dones", {move_done, abort_done}, 0);
    check("rst_rem", steps_remaining, 0);
    check("rst_ready_in_reset", sif.cmd_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready_after", sif.cmd_ready, 1);

    // basic move: 3 steps, period 20
    run_move(1'b0, 16'd3, 16'd20, 62, 0, 1'b0, 16'd0, 16'd0, 0);
    check("t1_step", step_v, win(1, 8) | win(21, 28) | win(41, 48));
    check("t1_move_done", md_v, win(60, 60));
    check("t1_busy", busy_v, win(1, 60));
    check("t1_enable", en_v, win(2, 61));
    check("t1_dir", dir_v, 0);
    check("t1_abort_done", ad_v, 0);
    check("t1_ready", rdy_v, win(1, 62));
    check("t1_rem1", rem_a[1], 2);
    check("t1_rem21", rem_a[21], 1);
    check("t1_rem41", rem_a[41], 0);

    // chained move with a direction change
    run_move(1'b0, 16'd2, 16'd20, 90, 3, 1'b1, 16'd2, 16'd20, 0);
    check("t2_step", step_v, win(1, 8) | win(21, 28) | win(45, 52) | win(65, 72));
    check("t2_move_done", md_v, win(40, 40) | win(84, 84));
    check("t2_busy", busy_v, win(1, 84));
    check("t2_enable", en_v, win(2, 85));
    check("t2_dir", dir_v, win(41, 90));
    check("t2_ready", rdy_v, win(1, 3) | win(41, 90));
    check("t2_rem41", rem_a[41], 2);
    check("t2_rem45", rem_a[45], 1);
    check("t2_rem65", rem_a[65], 0);

    // period below floor is clamped to 16
    run_move(1'b1, 16'd2, 16'd5, 40, 0, 1'b0, 16'd0, 16'd0, 0);
    check("t3_step", step_v, win(1, 8) | win(17, 24));
    check("t3_move_done", md_v, win(32, 32));
    check("t3_busy", busy_v, win(1, 32));
    check("t3_dir", dir_v, win(1, 40));

    // abort in 3rd high cycle of step 2 of 10, with a pending command
    run_move(1'b1, 16'd10, 16'd20, 40, 3, 1'b0, 16'd5, 16'd20, 23);
    check("t4_step", step_v, win(1, 8) | win(21, 28));
    check("t4_move_done", md_v, 0);
    check("t4_abort_done", ad_v, win(29, 29));
    check("t4_busy", busy_v, win(1, 28));
    check("t4_enable", en_v, win(2, 29));
    check("t4_dir", dir_v, win(1, 40));
    check("t4_ready", rdy_v, win(1, 3) | win(29, 40));
    check("t4_rem28", rem_a[28], 8);
    check("t4_rem29", rem_a[29], 0);

    // abort while idle, together with a command: no-op and not accepted
    abort = 1'b1; sif.cmd_valid = 1'b1;
    sif.cmd_dir = 1'b1; sif.cmd_steps = 16'd3; sif.cmd_period = 16'd20;
    #1 check("idle_abort_ready", sif.cmd_ready, 0);
    @(negedge clk);
    check("idle_abort_busy", {busy, step, abort_done}, 0);
    abort = 1'b0; sif.cmd_valid = 1'b0;
    @(negedge clk);
    check("idle_abort_after", {busy, step, abort_done}, 0);

    // zero-step move
    run_move(1'b0, 16'd0, 16'd20, 10, 0, 1'b0, 16'd0, 16'd0, 0);
    check("t5_step", step_v, 0);
    check("t5_move_done", md_v, win(1, 1));
    check("t5_busy", busy_v, win(1, 1));
    check("t5_enable", en_v, win(2, 2));
    check("t5_dir", dir_v, win(1, 10));
    check("t5_rem1", rem_a[1], 0);

    // hold_enable keeps the driver on while idle
    hold_enable = 1'b1;
    @(negedge clk);
    check("hold_on", {enable, busy}, 2'b10);
    hold_enable = 1'b0;
    @(negedge clk);
    check("hold_off", enable, 0);

    // reset in the middle of a pulse
    sif.cmd_dir = 1'b1; sif.cmd_steps = 16'd3; sif.cmd_period = 16'd20; sif.cmd_valid = 1'b1;
    @(posedge clk);
    #1 sif.cmd_valid = 1'b0;
    @(negedge clk);
    check("t6_step_before", step, 1);
    @(negedge clk);
    reset = 1'b1;
    #1 check("t6_ready_in_reset", sif.cmd_ready, 0);
    @(negedge clk);
    check("t6_after_reset", {step, enable, busy, dir, sif.cmd_ready}, 0);
    check("t6_rem", steps_remaining, 0);
    reset = 1'b0;
    @(negedge clk);
    check("t6_ready_after", sif.cmd_ready, 1);
    acc = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      acc = acc | step | move_done | abort_done;
    end
    check("t6_quiet", acc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
